// File: rtl/day6_col_sequencer_if.sv
// Column-sequencer bus bundle.
// Groups the worksheet memory read port and the column-streaming
// interface towards the day-6 column datapath.
//   mem_addr / mem_rd  : read request, data returns on mem_data one cycle later
//   dp_load            : one-cycle datapath clear pulse
//   dp_ready / dp_done : datapath flow control and completion
//   rN_digit/rN_space  : decoded digit rows of the emitted column
//   block_start, block_plus, col_valid, col_last, frame_last : column controls
// master = sequencer side, slave = memory/datapath side.
interface day6_col_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              dp_load;
    logic              dp_ready;
    logic              dp_done;
    logic [3:0]        r0_digit;
    logic [3:0]        r1_digit;
    logic [3:0]        r2_digit;
    logic [3:0]        r3_digit;
    logic              r0_space;
    logic              r1_space;
    logic              r2_space;
    logic              r3_space;
    logic              block_start;
    logic              block_plus;
    logic              col_valid;
    logic              col_last;
    logic              frame_last;

    modport master (
        output mem_addr, mem_rd, dp_load,
        output r0_digit, r1_digit, r2_digit, r3_digit,
        output r0_space, r1_space, r2_space, r3_space,
        output block_start, block_plus, col_valid, col_last, frame_last,
        input  mem_data, dp_ready, dp_done
    );

    modport slave (
        input  mem_addr, mem_rd, dp_load,
        input  r0_digit, r1_digit, r2_digit, r3_digit,
        input  r0_space, r1_space, r2_space, r3_space,
        input  block_start, block_plus, col_valid, col_last, frame_last,
        output mem_data, dp_ready, dp_done
    );
endinterface

// File: rtl/day6_col_sequencer.sv
// Day-6 column sequencer.
// Walks a character worksheet (4 digit rows + 1 operator row) column by
// column, decodes each column and streams non-separator columns to the
// column datapath with block / last markers.
// Ports:
//   clock, clear           : clock, synchronous active-high reset
//   start                  : begin a frame (accepted in IDLE or DONE)
//   cfg_base/stride/cols   : row-0 column-0 address, row pitch, column count
//   busy, done             : frame in progress / frame finished (sticky)
//   err_char, err_op       : sticky decode errors (bad digit byte, bad operator)
//   err_empty              : frame held no non-separator column
//   bus (master)           : memory read port and datapath column stream
module day6_col_sequencer #(
    parameter int ADDR_W = 16,
    parameter int COL_W  = 12
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [COL_W-1:0]  cfg_cols,
    output logic              busy,
    output logic              done,
    output logic              err_char,
    output logic              err_op,
    output logic              err_empty,
    day6_col_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FETCH, S_EVAL, S_FLUSH, S_WAIT_DONE, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Returns {bad, space, digit}. Bad bytes decode as space.
    function automatic logic [5:0] decode_byte(input logic [7:0] b);
        logic [5:0] res;
        if (b == 8'h20)
            res = 6'b01_0000;
        else if (b >= 8'h30 && b <= 8'h39)
            res = {2'b00, b[3:0]};
        else
            res = 6'b11_0000;
        return res;
    endfunction

    // Control registers
    logic [COL_W-1:0]  r_col;
    logic [2:0]        r_fcyc;
    logic              r_pend;
    logic              r_gap;
    logic              r_err_char;
    logic              r_err_op;
    logic              r_err_empty;

    // Data registers
    logic [ADDR_W-1:0] r_stride;
    logic [COL_W-1:0]  r_cols;
    logic [ADDR_W-1:0] r_colptr;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0][3:0]   r_cur_digit;
    logic [3:0]        r_cur_space;
    logic [7:0]        r_cur_op;
    logic [3:0][3:0]   r_pd_digit;
    logic [3:0]        r_pd_space;
    logic              r_pd_start;
    logic              r_pd_plus;

    logic [5:0]        w_dec;
    logic [1:0]        w_row;
    logic              w_sep;
    logic              w_op_bad;
    logic              w_new_start;
    logic              w_last_col;
    logic              w_emit_req;
    logic              w_eval_go;

    assign w_dec       = decode_byte(bus.mem_data);
    // Fetch cycles 1..4 capture digit rows 0..3.
    assign w_row       = r_fcyc[1:0] - 2'd1;
    assign w_sep       = &r_cur_space;
    assign w_op_bad    = !(r_cur_op == 8'h2B || r_cur_op == 8'h2A);
    // A loaded column opens a block if nothing is pending yet or a separator preceded it.
    assign w_new_start = !r_pend || r_gap;
    assign w_last_col  = (r_col + COL_W'(1)) == r_cols;
    assign w_emit_req  = r_pend && ((r_state == S_EVAL && !w_sep) || r_state == S_FLUSH);
    // EVAL only stalls when the pending column must be handed over and the datapath is busy.
    assign w_eval_go   = (r_state == S_EVAL) && (w_sep || !r_pend || bus.dp_ready);

    assign err_char  = r_err_char  & ~clear;
    assign err_op    = r_err_op    & ~clear;
    assign err_empty = r_err_empty & ~clear;

    always_ff @(posedge clock) begin
        if (clear)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        bus.mem_rd       = 1'b0;
        bus.mem_addr     = '0;
        bus.dp_load      = 1'b0;
        bus.r0_digit     = 4'd0;
        bus.r1_digit     = 4'd0;
        bus.r2_digit     = 4'd0;
        bus.r3_digit     = 4'd0;
        bus.r0_space     = 1'b0;
        bus.r1_space     = 1'b0;
        bus.r2_space     = 1'b0;
        bus.r3_space     = 1'b0;
        bus.block_start  = 1'b0;
        bus.block_plus   = 1'b0;
        bus.col_valid    = 1'b0;
        bus.col_last     = 1'b0;
        bus.frame_last   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_INIT;
            S_INIT:         w_next = (r_cols == '0) ? S_FLUSH : S_FETCH;
            S_FETCH:        if (r_fcyc == 3'd5) w_next = S_EVAL;
            S_EVAL:         if (w_eval_go) w_next = w_last_col ? S_FLUSH : S_FETCH;
            S_FLUSH: begin
                if (!r_pend)
                    w_next = S_DONE;
                else if (bus.dp_ready)
                    w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE:    if (bus.dp_done) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase

        // Outputs are forced idle for as long as clear is held.
        if (!clear) begin
            busy        = (r_state != S_IDLE) && (r_state != S_DONE);
            done        = (r_state == S_DONE);
            bus.dp_load = (r_state == S_INIT);
            if (r_state == S_FETCH && r_fcyc <= 3'd4) begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = r_addr;
            end
            if (w_emit_req) begin
                bus.r0_digit    = r_pd_digit[0];
                bus.r1_digit    = r_pd_digit[1];
                bus.r2_digit    = r_pd_digit[2];
                bus.r3_digit    = r_pd_digit[3];
                bus.r0_space    = r_pd_space[0];
                bus.r1_space    = r_pd_space[1];
                bus.r2_space    = r_pd_space[2];
                bus.r3_space    = r_pd_space[3];
                bus.block_start = r_pd_start;
                bus.block_plus  = r_pd_plus;
                bus.col_last    = (r_state == S_FLUSH) ? 1'b1 : r_gap;
                bus.frame_last  = (r_state == S_FLUSH);
                bus.col_valid   = bus.dp_ready;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_col       <= '0;
            r_fcyc      <= 3'd0;
            r_pend      <= 1'b0;
            r_gap       <= 1'b0;
            r_err_char  <= 1'b0;
            r_err_op    <= 1'b0;
            r_err_empty <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_err_char  <= 1'b0;
                        r_err_op    <= 1'b0;
                        r_err_empty <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_col  <= '0;
                    r_fcyc <= 3'd0;
                    r_pend <= 1'b0;
                    r_gap  <= 1'b0;
                end
                S_FETCH: begin
                    r_fcyc <= r_fcyc + 3'd1;
                    if (r_fcyc >= 3'd1 && r_fcyc <= 3'd4 && w_dec[5])
                        r_err_char <= 1'b1;
                end
                S_EVAL: begin
                    if (w_eval_go) begin
                        r_fcyc <= 3'd0;
                        r_col  <= r_col + COL_W'(1);
                        if (w_sep) begin
                            r_gap <= 1'b1;
                        end else begin
                            if (w_new_start && w_op_bad)
                                r_err_op <= 1'b1;
                            r_pend <= 1'b1;
                            r_gap  <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!r_pend)
                        r_err_empty <= 1'b1;
                    else if (bus.dp_ready)
                        r_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    r_stride <= cfg_stride;
                    r_cols   <= cfg_cols;
                    r_colptr <= cfg_base;
                    r_addr   <= cfg_base;
                end
            end
            S_FETCH: begin
                // Row addresses step by stride from the column pointer; no multiplier.
                if (r_fcyc <= 3'd4)
                    r_addr <= r_addr + r_stride;
                if (r_fcyc >= 3'd1 && r_fcyc <= 3'd4) begin
                    r_cur_digit[w_row] <= w_dec[3:0];
                    r_cur_space[w_row] <= w_dec[4];
                end
                if (r_fcyc == 3'd5)
                    r_cur_op <= bus.mem_data;
            end
            S_EVAL: begin
                if (w_eval_go) begin
                    r_colptr <= r_colptr + ADDR_W'(1);
                    r_addr   <= r_colptr + ADDR_W'(1);
                    if (!w_sep) begin
                        r_pd_digit <= r_cur_digit;
                        r_pd_space <= r_cur_space;
                        r_pd_start <= w_new_start;
                        r_pd_plus  <= w_new_start && (r_cur_op == 8'h2B);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
